// File: rtl/add_result_checker.sv
// Response-side checker for a registered adder. It delays each issued operand pair
// by LATENCY cycles, compares the adder output with the truncated sum, and reports the verdict.
module add_result_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int NCHECK  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [7:0]       chk_cnt_o,
    output logic [7:0]       err_cnt_o,
    output logic [WIDTH-1:0] fail_a_o,
    output logic [WIDTH-1:0] fail_b_o,
    output logic [WIDTH-1:0] fail_out_o
);

    localparam int         LAST      = LATENCY - 1;
    localparam logic [7:0] NCHECK_C  = 8'(NCHECK);
    localparam logic [7:0] NCHECK_M1 = 8'(NCHECK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [LATENCY-1:0] pipeValid_q;
    logic [WIDTH-1:0]   pipeExp_q [LATENCY];
    logic [WIDTH-1:0]   pipeA_q   [LATENCY];
    logic [WIDTH-1:0]   pipeB_q   [LATENCY];

    logic [7:0]       issueCnt_q;
    logic [7:0]       chkCnt_q;
    logic [7:0]       errCnt_q;
    logic             firstErr_q;
    logic [WIDTH-1:0] failA_q;
    logic [WIDTH-1:0] failB_q;
    logic [WIDTH-1:0] failOut_q;

    logic             startEntry;
    logic             issue;
    logic             lastValid;
    logic             lineEmpty;
    logic             mismatch;
    logic [WIDTH-1:0] expSum;

    assign startEntry = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign issue      = (state_q == S_RUN) && valid_i;
    assign lastValid  = pipeValid_q[LAST];
    assign lineEmpty  = ~|pipeValid_q;
    assign mismatch   = lastValid && (out_i != pipeExp_q[LAST]);
    assign expSum     = a_i + b_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (issue && (issueCnt_q == NCHECK_M1)) state_d = S_DRAIN;
            S_DRAIN: if (lineEmpty && (chkCnt_q == NCHECK_C)) state_d = S_DONE;
            S_DONE:  if (start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            S_RUN, S_DRAIN: busy_o = 1'b1;
            S_DONE:         done_o = 1'b1;
            default:        ;
        endcase
    end

    // Stage 0 loads every edge; outside RUN its valid bit is simply zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipeValid_q[i] <= 1'b0;
                pipeExp_q[i]   <= '0;
                pipeA_q[i]     <= '0;
                pipeB_q[i]     <= '0;
            end
        end else begin
            pipeValid_q[0] <= issue;
            pipeExp_q[0]   <= expSum;
            pipeA_q[0]     <= a_i;
            pipeB_q[0]     <= b_i;
            for (int i = 1; i < LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeExp_q[i]   <= pipeExp_q[i-1];
                pipeA_q[i]     <= pipeA_q[i-1];
                pipeB_q[i]     <= pipeB_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issueCnt_q <= '0;
        end else if (startEntry) begin
            issueCnt_q <= '0;
        end else if (issue) begin
            issueCnt_q <= issueCnt_q + 8'd1;
        end
    end

    // Only the first mismatch of a run is captured; the error count saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chkCnt_q   <= '0;
            errCnt_q   <= '0;
            firstErr_q <= 1'b0;
            failA_q    <= '0;
            failB_q    <= '0;
            failOut_q  <= '0;
        end else if (startEntry) begin
            chkCnt_q   <= '0;
            errCnt_q   <= '0;
            firstErr_q <= 1'b0;
            failA_q    <= '0;
            failB_q    <= '0;
            failOut_q  <= '0;
        end else if (lastValid) begin
            chkCnt_q <= chkCnt_q + 8'd1;
            if (mismatch) begin
                if (errCnt_q != 8'hFF) begin
                    errCnt_q <= errCnt_q + 8'd1;
                end
                if (!firstErr_q) begin
                    firstErr_q <= 1'b1;
                    failA_q    <= pipeA_q[LAST];
                    failB_q    <= pipeB_q[LAST];
                    failOut_q  <= out_i;
                end
            end
        end
    end

    assign pass_o     = done_o && (errCnt_q == 8'd0);
    assign chk_cnt_o  = chkCnt_q;
    assign err_cnt_o  = errCnt_q;
    assign fail_a_o   = failA_q;
    assign fail_b_o   = failB_q;
    assign fail_out_o = failOut_q;

endmodule

// File: tb/tb_add_result_checker.sv
// Self-checking bench: a bench-side registered adder feeds the checker, and a
// transaction-level model predicts every checker output each cycle.
module tb_add_result_checker;

    localparam int W   = 8;
    localparam int LAT = 1;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         faultEn = 1'b0;
    logic [W-1:0] faultVal = '0;
    logic [W-1:0] adderReg = '0;

    logic         busy, done, pass;
    logic [7:0]   chkCnt, errCnt;
    logic [W-1:0] failA, failB, failOut;

    int compared = 0;
    int mismatched = 0;

    add_result_checker #(.WIDTH(W), .LATENCY(LAT), .NCHECK(NCH)) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .start_i    (start),
        .valid_i    (valid),
        .a_i        (a),
        .b_i        (b),
        .out_i      (adderReg),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .chk_cnt_o  (chkCnt),
        .err_cnt_o  (errCnt),
        .fail_a_o   (failA),
        .fail_b_o   (failB),
        .fail_out_o (failOut)
    );

    always #5 clk = ~clk;

    // The adder under check: registered sum, optionally overridden to inject a fault.
    always @(posedge clk) begin
        adderReg <= faultEn ? faultVal : W'(a + b);
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending comparisons are kept as a queue of due cycles.
    typedef struct {
        int           due;
        logic [W-1:0] ex;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
    } pend_t;

    pend_t        pq[$];
    int           mCyc = 0;
    int           mState = 0;
    int           mIssued = 0;
    int           mChk = 0;
    int           mErr = 0;
    bit           mFirst = 1'b0;
    logic [W-1:0] mFa = '0;
    logic [W-1:0] mFb = '0;
    logic [W-1:0] mFo = '0;
    bit           drainDone;
    pend_t        pItem;

    // mState: 0 idle, 1 run, 2 drain, 3 done
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pq.delete();
            mCyc = 0; mState = 0; mIssued = 0; mChk = 0; mErr = 0;
            mFirst = 1'b0; mFa = '0; mFb = '0; mFo = '0;
        end else begin
            mCyc++;
            drainDone = (pq.size() == 0) && (mChk == NCH);
            if (pq.size() > 0 && pq[0].due == mCyc) begin
                pItem = pq.pop_front();
                mChk++;
                if (adderReg != pItem.ex) begin
                    if (mErr < 255) mErr++;
                    if (!mFirst) begin
                        mFirst = 1'b1;
                        mFa = pItem.pa;
                        mFb = pItem.pb;
                        mFo = adderReg;
                    end
                end
            end
            case (mState)
                0, 3: if (start) begin
                    mState = 1; mIssued = 0; mChk = 0; mErr = 0;
                    mFirst = 1'b0; mFa = '0; mFb = '0; mFo = '0;
                end
                1: if (valid) begin
                    pq.push_back('{mCyc + LAT, W'(a + b), a, b});
                    mIssued++;
                    if (mIssued == NCH) mState = 2;
                end
                2: if (drainDone) mState = 3;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("busy",    int'(busy),    int'(mState == 1 || mState == 2));
        checkOutput("done",    int'(done),    int'(mState == 3));
        checkOutput("pass",    int'(pass),    int'(mState == 3 && mErr == 0));
        checkOutput("chkCnt",  int'(chkCnt),  mChk);
        checkOutput("errCnt",  int'(errCnt),  mErr);
        checkOutput("failA",   int'(failA),   int'(mFa));
        checkOutput("failB",   int'(failB),   int'(mFb));
        checkOutput("failOut", int'(failOut), int'(mFo));
    end

    task automatic applyStimulus(input bit s, input bit v, input logic [W-1:0] aa,
                                 input logic [W-1:0] bb, input bit fe, input logic [W-1:0] fv);
        start = s; valid = v; a = aa; b = bb; faultEn = fe; faultVal = fv;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone();
        start = 1'b0; valid = 1'b0; faultEn = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("runDone", int'(done), 1);
    endtask

    task automatic runFour(input logic [W-1:0] fvThird, input bit faultThird);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 2, 0, 0);
        applyStimulus(0, 1, 3, 4, 0, 0);
        applyStimulus(0, 1, 5, 6, faultThird, fvThird);
        applyStimulus(0, 1, 7, 8, 0, 0);
        waitDone();
    endtask

    initial begin
        $display("[TB] reset then idle");
        for (int i = 0; i < 10; i++) applyStimulus(0, i[0], 8'(i), 8'(i), 0, 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetChk",  int'(chkCnt), 0);
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(0, ~i[0], 8'(i), 8'(3), 0, 0);
        checkOutput("idleChk",  int'(chkCnt), 0);
        checkOutput("idleDone", int'(done), 0);

        $display("[TB] correct adder");
        runFour(0, 0);
        checkOutput("goodPass", int'(pass), 1);
        checkOutput("goodChk",  int'(chkCnt), 4);
        checkOutput("goodErr",  int'(errCnt), 0);

        $display("[TB] injected fault");
        runFour(8'd12, 1);
        checkOutput("faultPass", int'(pass), 0);
        checkOutput("faultErr",  int'(errCnt), 1);
        checkOutput("faultA",    int'(failA), 5);
        checkOutput("faultB",    int'(failB), 6);
        checkOutput("faultOut",  int'(failOut), 12);

        $display("[TB] wrap-around");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 255, 1, 0, 0);
        applyStimulus(0, 1, 200, 100, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 128, 128, 0, 0);
        waitDone();
        checkOutput("wrapErr",  int'(errCnt), 0);
        checkOutput("wrapPass", int'(pass), 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 255, 1, 1, 8'd1);
        applyStimulus(0, 1, 200, 100, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 128, 128, 0, 0);
        waitDone();
        checkOutput("wrapBadErr", int'(errCnt), 1);
        checkOutput("wrapBadOut", int'(failOut), 1);

        $display("[TB] bubbles and ignored start");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 10, 20, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 30, 40, 0, 0);
        applyStimulus(0, 1, 50, 60, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 70, 80, 0, 0);
        waitDone();
        checkOutput("bubbleChk",  int'(chkCnt), 4);
        checkOutput("bubblePass", int'(pass), 1);

        $display("[TB] reset mid-run");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 2, 2, 0, 0);
        rstN = 1'b0;
        #1;
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortChk",  int'(chkCnt), 0);
        applyStimulus(0, 1, 3, 3, 0, 0);
        rstN = 1'b1;
        runFour(0, 0);
        checkOutput("freshPass", int'(pass), 1);
        checkOutput("freshChk",  int'(chkCnt), 4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rstN = 1'b0;
                applyStimulus(0, 0, 0, 0, 0, 0);
                rstN = 1'b1;
            end else begin
                applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                              8'($urandom), 8'($urandom),
                              $urandom_range(0, 9) == 0, 8'($urandom));
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/add_result_checker.md
# add_result_checker

Synthesizable response-side checker for the registered 8-bit adder path. It samples the operand stream (A, B) driven into the adder and, after a fixed pipeline latency, compares the adder's OUT against an internally computed expected sum. It reports a pass/fail verdict, counts checks and mismatches, and captures the first failing triple, so the adder can be self-checked on-chip or in regression without waveform inspection.

## Interface

Parameters:
- WIDTH, 8, operand/result width
- LATENCY, 1, cycles from operand sample to valid OUT (legal 1..4)
- NCHECK, 16, number of operand pairs per run (legal 1..255)

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse; begins a run
- VALID  in  1  A/B presented to the adder this cycle
- A  in  WIDTH  operand A, as driven to the adder
- B  in  WIDTH  operand B, as driven to the adder
- OUT  in  WIDTH  adder result under check
- BUSY  out  1  run in progress (RUN or DRAIN)
- DONE  out  1  run complete; held until next START
- PASS  out  1  DONE and zero mismatches
- CHK_CNT  out  8  comparisons performed this run
- ERR_CNT  out  8  mismatches this run, saturating at 255
- FAIL_A  out  WIDTH  A of first mismatch
- FAIL_B  out  WIDTH  B of first mismatch
- FAIL_OUT  out  WIDTH  observed OUT of first mismatch

## Operation

- Expected value = (A + B) mod 2^WIDTH; carry-out discarded (e.g. 200+100 expects 44).
- Delay line: LATENCY stages each holding {valid, expected, A, B}; stage 0 loads on every CLK edge.
- Comparison happens when the last stage's valid is 1: CHK_CNT increments; if OUT differs from stored expected, ERR_CNT increments (saturating). The first mismatch of a run loads FAIL_A/FAIL_B/FAIL_OUT; later mismatches leave them unchanged.
- FSM states:
  - IDLE: reset state. VALID is ignored (stage-0 valid forced 0).
  - RUN: entered on START from IDLE or DONE. Entry clears CHK_CNT, ERR_CNT, FAIL_* and the first-error flag. Each VALID cycle issues a pair and increments an issue counter. After the NCHECK-th issue, go to DRAIN.
  - DRAIN: VALID is ignored. Stay until the delay line is empty and CHK_CNT equals NCHECK, then go to DONE.
  - DONE: DONE=1, and PASS = (ERR_CNT==0). START returns to RUN; VALID is ignored.
- START while in RUN or DRAIN is ignored.
- START coincident with VALID on the entry cycle: that VALID is not issued. Issue begins the cycle after entry.
- BUSY=1 in RUN and DRAIN only.

## Timing

- Reset (RESET=0, asynchronous): state IDLE, delay line cleared. BUSY, DONE and PASS are 0; CHK_CNT and ERR_CNT are 0; FAIL_* are 0.
- Reset asserted mid-run aborts immediately, with no verdict. After release, the block waits in IDLE for START.
- With LATENCY=1, a pair sampled at edge k is compared against OUT at edge k+1. This matches the adder's registered output: the adder captures at edge k and OUT is valid before edge k+1.
- General case: compare at edge k+LATENCY.
- Counter updates and FAIL_* capture are visible the cycle after the compare edge.
- DONE rises the cycle after the final compare updates CHK_CNT to NCHECK. PASS is combinational from DONE and ERR_CNT.
- Gaps in VALID are allowed at any time during RUN. They insert bubbles, and no compare occurs for a bubble.
- Minimum run length is NCHECK + LATENCY + 2 cycles from START.

## Test plan

- Reset then idle: RESET low 100 ns then release, VALID toggling, no START -> all outputs 0, CHK_CNT stays 0.
- Correct adder, LATENCY=1, NCHECK=4, pairs (1,2), (3,4), (5,6), (7,8) one per cycle with OUT = 3, 7, 11, 15 one cycle later -> DONE=1, PASS=1, CHK_CNT=4, ERR_CNT=0.
- Injected fault, same pairs with OUT for (5,6) forced to 12 -> ERR_CNT=1, PASS=0, FAIL_A=5, FAIL_B=6, FAIL_OUT=12.
- Wrap-around: pairs (255,1) and (200,100) with OUT = 0 and 44 -> no mismatch. OUT = 256-truncated-wrong value 1 for (255,1) -> ERR_CNT=1.
- Bubbles plus ignored START: VALID pattern 1,0,1,1,0,1 with START pulsed mid-run -> run is not restarted, CHK_CNT=4 at DONE.
- Reset mid-run after 2 of 4 pairs -> outputs clear asynchronously. A fresh START with 4 good pairs then gives PASS=1 and CHK_CNT=4.
